// File: rtl/bus_trace_pkg.sv
// Shared definitions for the C64 bus-cycle trace logger: register map, bit positions, FIFO entry layout.
// Define BUS_TRACE_TIMESTAMP_EN to add an 8-bit inter-entry cycle delta to every entry.
package bus_trace_pkg;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_STATUS     = 4'd1;
  localparam logic [3:0] REG_COUNT      = 4'd2;
  localparam logic [3:0] REG_THRESH     = 4'd3;
  localparam logic [3:0] REG_HEAD_ALO   = 4'd4;
  localparam logic [3:0] REG_HEAD_AHI   = 4'd5;
  localparam logic [3:0] REG_HEAD_D     = 4'd6;
  localparam logic [3:0] REG_HEAD_FLAGS = 4'd7;
  localparam logic [3:0] REG_POP        = 4'd8;
  localparam logic [3:0] REG_MATCH_LO   = 4'd9;
  localparam logic [3:0] REG_MATCH_HI   = 4'd10;
  localparam logic [3:0] REG_MASK_LO    = 4'd11;
  localparam logic [3:0] REG_MASK_HI    = 4'd12;
  localparam logic [3:0] REG_TSTAMP     = 4'd13;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_WRITES_ONLY = 2;
  localparam int CTRL_CLEAR       = 6;

  localparam int STAT_OVERFLOW = 7;
  localparam int STAT_FULL     = 6;
  localparam int STAT_EMPTY    = 5;
  localparam int STAT_IRQ      = 4;

`ifdef BUS_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 33;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic [7:0]  dt;
  } entry_t;
`else
  localparam int ENTRY_W = 25;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
  } entry_t;
`endif

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO with a registered head word; clear has priority over push and pop,
// and a push into a full FIFO succeeds only when a pop frees a slot in the same clock.
module trace_fifo #(
  parameter int W          = 25,
  parameter int DEPTH_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                clear,
  input  logic [W-1:0]        din,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] count,
  output logic [W-1:0]        head
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] ONE_CNT   = (DEPTH_BITS + 1)'(1);

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] rd_next;
  logic [DEPTH_BITS:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == DEPTH_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_next = rd_ptr + 1'b1;
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      cnt <= cnt + (DEPTH_BITS + 1)'(do_push) - (DEPTH_BITS + 1)'(do_pop);
    end
  end

  // Head tracks the oldest entry; a push into an emptying FIFO bypasses the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
    end else if (!clear) begin
      if (do_pop) begin
        head <= (cnt == ONE_CNT) ? din : mem[rd_next];
      end else if (do_push && empty) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/bus_trace_capture.sv
// Passive C64 bus-cycle logger with a 16-byte register aperture for FIFO readback.
// Optional build macro BUS_TRACE_TIMESTAMP_EN adds per-entry cycle deltas (register 13).
module bus_trace_capture
  import bus_trace_pkg::*;
#(
  parameter int DEPTH_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle_tick,
  input  logic [15:0] bus_a,
  input  logic [7:0]  bus_d,
  input  logic        bus_rw,
  input  logic        exclude,
  input  logic [3:0]  a,
  input  logic [7:0]  d_d,
  output logic [7:0]  d_q,
  input  logic        read_strobe,
  input  logic        write_strobe,
  output logic        irq
);

  // Register access: write_strobe is a single-clk pulse that commits d_d to register a in
  // that clk; reads are purely combinational on a, so read_strobe carries no side effects.
  logic        enable, irq_en, writes_only;
  logic [7:0]  thresh;
  logic [15:0] match, mask;
  logic        overflow;
  logic        irq_q;

  logic                wr_ctrl, clear, pop_req, capture, addr_hit;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_BITS:0] fifo_count;
  logic [ENTRY_W-1:0]  head_bits;
  entry_t              new_entry, head_entry;
  logic                unused_inputs;

  assign unused_inputs = read_strobe;

  assign wr_ctrl  = write_strobe && (a == REG_CTRL);
  assign clear    = wr_ctrl && d_d[CTRL_CLEAR];
  assign pop_req  = write_strobe && (a == REG_POP);
  assign addr_hit = ((bus_a ^ match) & mask) == 16'h0000;
  assign capture  = cycle_tick & enable & ~exclude & addr_hit & (~writes_only | ~bus_rw);

`ifdef BUS_TRACE_TIMESTAMP_EN
  logic [7:0] dt_cnt, dt_next;
  logic       stored;

  assign dt_next = (dt_cnt == 8'hFF) ? 8'hFF : dt_cnt + 8'd1;
  assign stored  = capture & (~fifo_full | (pop_req & ~fifo_empty));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dt_cnt <= 8'h00;
    end else if (cycle_tick) begin
      dt_cnt <= stored ? 8'h00 : dt_next;
    end
  end
`endif

  always_comb begin
    new_entry      = '0;
    new_entry.addr = bus_a;
    new_entry.data = bus_d;
    new_entry.rw   = bus_rw;
`ifdef BUS_TRACE_TIMESTAMP_EN
    new_entry.dt   = dt_next;
`endif
  end

  assign head_entry = entry_t'(head_bits);

  trace_fifo #(
    .W          (ENTRY_W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop_req),
    .clear (clear),
    .din   (new_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_bits)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= 1'b0;
      irq_en      <= 1'b0;
      writes_only <= 1'b0;
      thresh      <= 8'h00;
      match       <= 16'h0000;
      mask        <= 16'h0000;
    end else if (write_strobe) begin
      case (a)
        REG_CTRL: begin
          enable      <= d_d[CTRL_ENABLE];
          irq_en      <= d_d[CTRL_IRQ_EN];
          writes_only <= d_d[CTRL_WRITES_ONLY];
        end
        REG_THRESH:   thresh      <= d_d;
        REG_MATCH_LO: match[7:0]  <= d_d;
        REG_MATCH_HI: match[15:8] <= d_d;
        REG_MASK_LO:  mask[7:0]   <= d_d;
        REG_MASK_HI:  mask[15:8]  <= d_d;
        default: ;
      endcase
    end
  end

  // A pop while full frees the slot the coincident capture needs, so that is not an overflow.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overflow <= 1'b0;
    end else if (capture && fifo_full && !pop_req) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en && (8'(fifo_count) >= thresh) && (thresh != 8'h00);
    end
  end

  assign irq = irq_q;

  always_comb begin
    d_q = 8'h00;
    case (a)
      REG_CTRL:       d_q = {5'b0, writes_only, irq_en, enable};
      REG_STATUS:     d_q = {overflow, fifo_full, fifo_empty, irq_q, 4'b0};
      REG_COUNT:      d_q = 8'(fifo_count);
      REG_THRESH:     d_q = thresh;
      REG_HEAD_ALO:   d_q = fifo_empty ? 8'h00 : head_entry.addr[7:0];
      REG_HEAD_AHI:   d_q = fifo_empty ? 8'h00 : head_entry.addr[15:8];
      REG_HEAD_D:     d_q = fifo_empty ? 8'h00 : head_entry.data;
      REG_HEAD_FLAGS: d_q = fifo_empty ? 8'h00 : {7'b0, head_entry.rw};
      REG_MATCH_LO:   d_q = match[7:0];
      REG_MATCH_HI:   d_q = match[15:8];
      REG_MASK_LO:    d_q = mask[7:0];
      REG_MASK_HI:    d_q = mask[15:8];
`ifdef BUS_TRACE_TIMESTAMP_EN
      REG_TSTAMP:     d_q = fifo_empty ? 8'h00 : head_entry.dt;
`endif
      default:        d_q = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_bus_trace_capture.sv
// Self-checking bench for bus_trace_capture: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_bus_trace_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cycle_tick = 1'b0;
  logic [15:0] bus_a = 16'h0;
  logic [7:0]  bus_d = 8'h0;
  logic        bus_rw = 1'b0;
  logic        exclude = 1'b0;
  logic [3:0]  reg_a = 4'h0;
  logic [7:0]  d_d = 8'h0;
  logic [7:0]  d_q;
  logic        read_strobe = 1'b0;
  logic        write_strobe = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  bus_trace_capture #(.DEPTH_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .cycle_tick   (cycle_tick),
    .bus_a        (bus_a),
    .bus_d        (bus_d),
    .bus_rw       (bus_rw),
    .exclude      (exclude),
    .a            (reg_a),
    .d_d          (d_d),
    .d_q          (d_q),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .irq          (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic op(input bit tk, input logic [15:0] ba, input logic [7:0] bd, input bit br,
                    input bit ex, input bit wr, input logic [3:0] ra, input logic [7:0] rd);
    @(negedge clk);
    cycle_tick = tk; bus_a = ba; bus_d = bd; bus_rw = br; exclude = ex;
    write_strobe = wr; reg_a = ra; d_d = rd;
    @(posedge clk);
    #1;
    cycle_tick = 1'b0; write_strobe = 1'b0;
  endtask

  task automatic tick(input logic [15:0] ba, input logic [7:0] bd, input bit br, input bit ex);
    op(1'b1, ba, bd, br, ex, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic reg_wr(input logic [3:0] ra, input logic [7:0] rd);
    op(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1, ra, rd);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input logic [3:0] ra, input logic [7:0] exp, input string name);
    @(negedge clk);
    reg_a = ra;
    read_strobe = 1'b1;
    #1;
    check8(name, d_q, exp);
    @(posedge clk);
    #1 read_strobe = 1'b0;
  endtask

  task automatic irq_chk(input bit exp, input string name);
    @(negedge clk);
    check8(name, {7'b0, irq}, {7'b0, exp});
  endtask

  // ---------------- vector table ----------------
  typedef enum int {K_TICK, K_WR, K_RD} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] ba;
    logic [7:0]  bd;
    logic        br;
    logic        ex;
    logic [3:0]  ra;
    logic [7:0]  val;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vt(input logic [15:0] ba, input logic [7:0] bd, input logic br, input logic ex);
    vec_t v;
    v.kind = K_TICK; v.ba = ba; v.bd = bd; v.br = br; v.ex = ex; v.ra = 4'h0; v.val = 8'h0; v.name = "tick";
    return v;
  endfunction

  function automatic vec_t vw(input logic [3:0] ra, input logic [7:0] val);
    vec_t v;
    v.kind = K_WR; v.ba = 16'h0; v.bd = 8'h0; v.br = 1'b0; v.ex = 1'b0; v.ra = ra; v.val = val; v.name = "write";
    return v;
  endfunction

  function automatic vec_t vr(input logic [3:0] ra, input logic [7:0] val, input string name);
    vec_t v;
    v.kind = K_RD; v.ba = 16'h0; v.bd = 8'h0; v.br = 1'b0; v.ex = 1'b0; v.ra = ra; v.val = val; v.name = name;
    return v;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  logic [24:0] exp_q[$];
  bit          m_en, m_wo, m_ovf;
  logic [15:0] m_match, m_mask;

  task automatic model_step(input bit tk, input logic [15:0] ba, input logic [7:0] bd,
                            input bit br, input bit ex, input bit pp);
    bit hit;
    hit = tk && m_en && !ex && (((ba ^ m_match) & m_mask) == 16'h0) && (!m_wo || !br);
    if (pp && exp_q.size() > 0) void'(exp_q.pop_front());
    if (hit) begin
      if (exp_q.size() < 32) exp_q.push_back({ba, bd, br});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [24:0] h;
    logic [7:0]  st;
    @(posedge clk);
    st = {m_ovf, exp_q.size() == 32, exp_q.size() == 0, 1'b0, 4'b0};
    rd_chk(4'd2, 8'(exp_q.size()), {tag, "_count"});
    rd_chk(4'd1, st, {tag, "_status"});
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      rd_chk(4'd4, h[16:9], {tag, "_head_alo"});
      rd_chk(4'd5, h[24:17], {tag, "_head_ahi"});
      rd_chk(4'd6, h[8:1], {tag, "_head_d"});
      rd_chk(4'd7, {7'b0, h[0]}, {tag, "_head_flags"});
    end
  endtask

  // ---------------- test ----------------
  initial begin
    // Directed table following the register-level bring-up sequence.
    vecs.push_back(vw(4'd0, 8'h01));
    vecs.push_back(vt(16'hDE00, 8'h12, 1'b0, 1'b0));
    vecs.push_back(vt(16'h8000, 8'hA9, 1'b1, 1'b0));
    vecs.push_back(vt(16'hD020, 8'h05, 1'b0, 1'b0));
    vecs.push_back(vr(4'd2, 8'h03, "basic_count"));
    vecs.push_back(vr(4'd4, 8'h00, "basic_head_alo"));
    vecs.push_back(vr(4'd5, 8'hDE, "basic_head_ahi"));
    vecs.push_back(vr(4'd6, 8'h12, "basic_head_d"));
    vecs.push_back(vr(4'd7, 8'h00, "basic_head_flags"));
    vecs.push_back(vw(4'd8, 8'h00));
    vecs.push_back(vr(4'd4, 8'h00, "pop1_head_alo"));
    vecs.push_back(vr(4'd5, 8'h80, "pop1_head_ahi"));
    vecs.push_back(vr(4'd6, 8'hA9, "pop1_head_d"));
    vecs.push_back(vr(4'd7, 8'h01, "pop1_head_flags"));
    vecs.push_back(vw(4'd8, 8'h00));
    vecs.push_back(vw(4'd8, 8'h00));
    vecs.push_back(vr(4'd1, 8'h20, "pop3_status"));
    vecs.push_back(vw(4'd8, 8'h00));
    vecs.push_back(vr(4'd1, 8'h20, "pop_empty_status"));
    vecs.push_back(vr(4'd2, 8'h00, "pop_empty_count"));
    vecs.push_back(vr(4'd6, 8'h00, "pop_empty_head_d"));
    vecs.push_back(vw(4'd9, 8'h00));
    vecs.push_back(vw(4'd10, 8'hD0));
    vecs.push_back(vw(4'd11, 8'h00));
    vecs.push_back(vw(4'd12, 8'hFF));
    vecs.push_back(vw(4'd0, 8'h05));
    vecs.push_back(vr(4'd0, 8'h05, "ctrl_readback"));
    vecs.push_back(vr(4'd10, 8'hD0, "match_hi_readback"));
    vecs.push_back(vr(4'd12, 8'hFF, "mask_hi_readback"));
    vecs.push_back(vt(16'hD020, 8'h01, 1'b0, 1'b0));
    vecs.push_back(vt(16'hD021, 8'h02, 1'b1, 1'b0));
    vecs.push_back(vt(16'hC000, 8'h03, 1'b0, 1'b0));
    vecs.push_back(vt(16'hD0FF, 8'h04, 1'b0, 1'b1));
    vecs.push_back(vr(4'd2, 8'h01, "filter_count"));
    vecs.push_back(vr(4'd4, 8'h20, "filter_head_alo"));
    vecs.push_back(vr(4'd5, 8'hD0, "filter_head_ahi"));
    vecs.push_back(vr(4'd6, 8'h01, "filter_head_d"));

    do_reset();
    for (int r = 0; r < 16; r++) begin
      rd_chk(4'(r), (r == 1) ? 8'h20 : 8'h00, $sformatf("reset_reg%0d", r));
    end
    irq_chk(1'b0, "reset_irq");

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_TICK:  tick(vecs[i].ba, vecs[i].bd, vecs[i].br, vecs[i].ex);
        K_WR:    reg_wr(vecs[i].ra, vecs[i].val);
        default: rd_chk(vecs[i].ra, vecs[i].val, vecs[i].name);
      endcase
    end

    // Fill to full, capture coincident with pop while full, then overflow and clear.
    reg_wr(4'd12, 8'h00);
    reg_wr(4'd0, 8'h41);
    rd_chk(4'd2, 8'h00, "clear_count");
    for (int i = 0; i < 32; i++) tick(16'h1000 + 16'(i), 8'(i), 1'b0, 1'b0);
    rd_chk(4'd2, 8'h20, "full_count");
    rd_chk(4'd1, 8'h40, "full_status");
    rd_chk(4'd4, 8'h00, "full_head_alo");
    op(1'b1, 16'h2000, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd8, 8'h00);
    rd_chk(4'd2, 8'h20, "full_poppush_count");
    rd_chk(4'd1, 8'h40, "full_poppush_status");
    rd_chk(4'd4, 8'h01, "full_poppush_head_alo");
    tick(16'h3000, 8'hBB, 1'b0, 1'b0);
    rd_chk(4'd1, 8'hC0, "overflow_status");
    rd_chk(4'd2, 8'h20, "overflow_count");
    for (int i = 0; i < 31; i++) reg_wr(4'd8, 8'h00);
    rd_chk(4'd5, 8'h20, "last_head_ahi");
    rd_chk(4'd6, 8'hAA, "last_head_d");
    rd_chk(4'd1, 8'h80, "overflow_sticky_status");
    reg_wr(4'd0, 8'h41);
    rd_chk(4'd2, 8'h00, "ctrl_clear_count");
    rd_chk(4'd1, 8'h20, "ctrl_clear_status");
    rd_chk(4'd0, 8'h01, "ctrl_clear_ctrl");

    // Capture with pop at COUNT=1, then capture coincident with clear.
    tick(16'h4000, 8'h11, 1'b0, 1'b0);
    op(1'b1, 16'h4001, 8'h22, 1'b0, 1'b0, 1'b1, 4'd8, 8'h00);
    rd_chk(4'd2, 8'h01, "poppush1_count");
    rd_chk(4'd6, 8'h22, "poppush1_head_d");
    op(1'b1, 16'h4002, 8'h33, 1'b0, 1'b0, 1'b1, 4'd0, 8'h41);
    rd_chk(4'd2, 8'h00, "clear_vs_capture_count");
    rd_chk(4'd1, 8'h20, "clear_vs_capture_status");

    // Threshold interrupt timing.
    reg_wr(4'd3, 8'h04);
    reg_wr(4'd0, 8'h03);
    for (int i = 0; i < 3; i++) tick(16'h5000 + 16'(i), 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    irq_chk(1'b0, "irq_below_thresh");
    tick(16'h5003, 8'h00, 1'b0, 1'b0);
    irq_chk(1'b0, "irq_one_clk_after_tick");
    irq_chk(1'b1, "irq_two_clk_after_tick");
    rd_chk(4'd1, 8'h10, "irq_status");
    reg_wr(4'd8, 8'h00);
    irq_chk(1'b1, "irq_pop_same_clk");
    irq_chk(1'b0, "irq_after_pop");
    reg_wr(4'd3, 8'h00);
    reg_wr(4'd0, 8'h43);
    for (int i = 0; i < 5; i++) tick(16'h6000 + 16'(i), 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    irq_chk(1'b0, "irq_thresh_zero");

`ifdef BUS_TRACE_TIMESTAMP_EN
    reg_wr(4'd0, 8'h41);
    for (int i = 0; i < 10; i++) tick(16'h7000, 8'h00, 1'b0, 1'b1);
    tick(16'h7001, 8'h01, 1'b0, 1'b0);
    rd_chk(4'd13, 8'd11, "tstamp_after_clear");
    for (int i = 0; i < 300; i++) tick(16'h7002, 8'h00, 1'b0, 1'b1);
    tick(16'h7003, 8'h02, 1'b0, 1'b0);
    reg_wr(4'd8, 8'h00);
    rd_chk(4'd13, 8'hFF, "tstamp_saturate");
`else
    tick(16'h7001, 8'h01, 1'b0, 1'b0);
    rd_chk(4'd13, 8'h00, "tstamp_disabled");
`endif

    // Reset asserted in the same clk as a capture.
    @(negedge clk);
    cycle_tick = 1'b1; bus_a = 16'h7777; exclude = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 cycle_tick = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    rd_chk(4'd2, 8'h00, "reset_mid_capture_count");
    rd_chk(4'd1, 8'h20, "reset_mid_capture_status");
    rd_chk(4'd0, 8'h00, "reset_mid_capture_ctrl");

    // Randomized traffic against the queue model.
    m_match = 16'($urandom);
    m_mask  = 16'($urandom_range(0, 3));
    m_wo    = 1'($urandom_range(0, 1));
    m_en    = 1'b1;
    m_ovf   = 1'b0;
    exp_q.delete();
    reg_wr(4'd9, m_match[7:0]);
    reg_wr(4'd10, m_match[15:8]);
    reg_wr(4'd11, m_mask[7:0]);
    reg_wr(4'd12, m_mask[15:8]);
    reg_wr(4'd0, {5'b0, m_wo, 1'b0, 1'b1});
    for (int it = 0; it < 600; it++) begin
      int r;
      logic [15:0] ba;
      logic [7:0]  bd;
      bit br, ex, pp;
      r  = $urandom_range(0, 19);
      ba = 16'($urandom);
      bd = 8'($urandom);
      br = 1'($urandom_range(0, 1));
      ex = ($urandom_range(0, 7) == 0);
      if (it == 300) begin
        reg_wr(4'd0, {5'b0, m_wo, 1'b0, 1'b1} | 8'h40);
        exp_q.delete();
        m_ovf = 1'b0;
      end
      if (r <= 13) begin
        pp = (r == 13);
        op(1'b1, ba, bd, br, ex, pp, 4'd8, 8'h00);
        model_step(1'b1, ba, bd, br, ex, pp);
      end else if (r == 14) begin
        reg_wr(4'd8, 8'h00);
        model_step(1'b0, ba, bd, br, ex, 1'b1);
      end else begin
        check_model("rand");
      end
    end
    check_model("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
